// File: rtl/mem_stage_if.sv
// Execute-to-memory stage signal bundle: stall vector, EX bus and SRAM read data in; WB and bypass buses out.
// The slave modport is the memory stage; the master modport is the surrounding pipeline.
interface mem_stage_if;
    localparam int unsigned EX_TO_MEM_WD = 79;
    localparam int unsigned MEM_TO_WB_WD = 70;
    localparam int unsigned MEM_TO_RF_WD = 38;
    localparam int unsigned STALL_WD     = 6;

    logic [STALL_WD-1:0]     stall;
    logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus;
    logic [31:0]             data_sram_rdata;
    logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus;
    logic [MEM_TO_RF_WD-1:0] mem_to_rf_bus;
    logic                    mem_adel;

    modport master (
        output stall,
        output ex_to_mem_bus,
        output data_sram_rdata,
        input  mem_to_wb_bus,
        input  mem_to_rf_bus,
        input  mem_adel
    );

    modport slave (
        input  stall,
        input  ex_to_mem_bus,
        input  data_sram_rdata,
        output mem_to_wb_bus,
        output mem_to_rf_bus,
        output mem_adel
    );
endinterface

// File: rtl/mem_stage.sv
// MIPS pipeline stage 4: registers the EX bus, extracts/extends load data, holds one SRAM word across stalls.
// Optional misaligned-load detection is enabled by defining MEM_ADEL_CHECK_EN.
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    mem_stage_if.slave  mem_bus
);
    localparam int unsigned EX_TO_MEM_WD = 79;
    localparam int unsigned STALL_SELF   = 3;
    localparam int unsigned STALL_WB     = 4;

    localparam logic [2:0] LD_LB  = 3'b001;
    localparam logic [2:0] LD_LBU = 3'b010;
    localparam logic [2:0] LD_LH  = 3'b011;
    localparam logic [2:0] LD_LHU = 3'b100;
    localparam logic [2:0] LD_LW  = 3'b101;

    logic [EX_TO_MEM_WD-1:0] r_ex_to_mem;
    logic [31:0]             r_hold_data;
    logic                    r_hold_vld;

    logic        w_stall_self;
    logic        w_stall_wb;
    logic [2:0]  w_ld_op;
    logic [31:0] w_pc;
    logic        w_ram_en;
    logic [3:0]  w_ram_wen;
    logic        w_sel_rf_res;
    logic        w_rf_we_raw;
    logic [4:0]  w_rf_waddr;
    logic [31:0] w_ex_result;
    logic [1:0]  w_off;
    logic [31:0] w_word;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_result;
    logic [31:0] w_rf_wdata;
    logic        w_adel;
    logic        w_rf_we;
    logic        w_unused;

    assign w_stall_self = mem_bus.stall[STALL_SELF];
    assign w_stall_wb   = mem_bus.stall[STALL_WB];

    assign w_ld_op      = r_ex_to_mem[78:76];
    assign w_pc         = r_ex_to_mem[75:44];
    assign w_ram_en     = r_ex_to_mem[43];
    assign w_ram_wen    = r_ex_to_mem[42:39];
    assign w_sel_rf_res = r_ex_to_mem[38];
    assign w_rf_we_raw  = r_ex_to_mem[37];
    assign w_rf_waddr   = r_ex_to_mem[36:32];
    assign w_ex_result  = r_ex_to_mem[31:0];
    assign w_off        = w_ex_result[1:0];

    // Pipeline register plus the one-word hold buffer; hold is discarded whenever r is rewritten.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex_to_mem <= '0;
            r_hold_data <= '0;
            r_hold_vld  <= 1'b0;
        end else if (w_stall_self && !w_stall_wb) begin
            r_ex_to_mem <= '0;
            r_hold_vld  <= 1'b0;
        end else if (!w_stall_self) begin
            r_ex_to_mem <= mem_bus.ex_to_mem_bus;
            r_hold_vld  <= 1'b0;
        end else if (w_ram_en && !r_hold_vld) begin
            r_hold_data <= mem_bus.data_sram_rdata;
            r_hold_vld  <= 1'b1;
        end
    end

    // Load extraction: the held word takes over once the live SRAM data may have moved on.
    always_comb begin
        w_word = r_hold_vld ? r_hold_data : mem_bus.data_sram_rdata;
        case (w_off)
            2'd0:    w_byte = w_word[7:0];
            2'd1:    w_byte = w_word[15:8];
            2'd2:    w_byte = w_word[23:16];
            default: w_byte = w_word[31:24];
        endcase
        w_half = w_off[1] ? w_word[31:16] : w_word[15:0];
        case (w_ld_op)
            LD_LB:   w_load_result = {{24{w_byte[7]}}, w_byte};
            LD_LBU:  w_load_result = {24'd0, w_byte};
            LD_LH:   w_load_result = {{16{w_half[15]}}, w_half};
            LD_LHU:  w_load_result = {16'd0, w_half};
            LD_LW:   w_load_result = w_word;
            default: w_load_result = w_ex_result;
        endcase
    end

    assign w_rf_wdata = w_sel_rf_res ? w_load_result : w_ex_result;

`ifdef MEM_ADEL_CHECK_EN
    assign w_adel = (((w_ld_op == LD_LH) || (w_ld_op == LD_LHU)) && w_off[0])
                  || ((w_ld_op == LD_LW) && (w_off != 2'd0));
`else
    assign w_adel = 1'b0;
`endif

    assign w_rf_we = w_rf_we_raw & ~w_adel;

    assign mem_bus.mem_to_wb_bus = {w_pc, w_rf_we, w_rf_waddr, w_rf_wdata};
    assign mem_bus.mem_to_rf_bus = {w_rf_we, w_rf_waddr, w_rf_wdata};
    assign mem_bus.mem_adel      = w_adel;

    // Store byte enables and the other stages' stall bits are not consumed here.
    assign w_unused = ^{w_ram_wen, mem_bus.stall[5], mem_bus.stall[2:0]};

endmodule
